// File: rtl/axis_frame_arb_if.sv
// AXI-Stream bundle shared by the arbiter's source and sink sides.
// N lanes of tdata/tvalid/tready/tlast plus a tid tag (sink side only).
interface axis_frame_arb_if #(
  parameter int DW  = 32,
  parameter int N   = 1,
  parameter int IDW = 1
);
  logic [N*DW-1:0] tdata;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tready;
  logic [N-1:0]    tlast;
  logic [IDW-1:0]  tid;

  modport master (
    output tdata, tvalid, tlast, tid,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_frame_arb.sv
// Frame-level round-robin AXI-Stream arbiter with one registered output stage.
// Ports: clk, rst (sync, high); s_axis (NUM_SRC lanes, slave); m_axis (master,
// tid = source); frame_cnt; oversize_err (sticky truncation flag); busy.
module axis_frame_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int MAX_BEATS  = 256
) (
  input  logic            clk,
  input  logic            rst,
  axis_frame_arb_if.slave  s_axis,
  axis_frame_arb_if.master m_axis,
  output logic [15:0]     frame_cnt,
  output logic            oversize_err,
  output logic            busy
);

  localparam int BW = $clog2(MAX_BEATS);
  localparam logic [0:0] S_ARB  = 1'b0;
  localparam logic [0:0] S_PASS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   sel_q, sel_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH:0]     idx;
  logic                  found;

  logic [DATA_WIDTH-1:0] dat_q;
  logic                  vld_q;
  logic                  lst_q;
  logic [ID_WIDTH-1:0]   tid_q;
  logic [15:0]           fcnt_q;
  logic                  err_q;

  logic load_out;
  logic acc;
  logic cap;
  logic last_in;
  logic fend;
  logic out_hs;

  // First requester at or above rr_q, wrapping modulo NUM_SRC.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, rr_q} + (ID_WIDTH+1)'(k);
      if (idx >= (ID_WIDTH+1)'(NUM_SRC))
        idx = idx - (ID_WIDTH+1)'(NUM_SRC);
      if (!found && s_axis.tvalid[idx[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign load_out = ~vld_q | m_axis.tready[0];
  assign out_hs   = vld_q & m_axis.tready[0];
  assign acc      = (state_q == S_PASS)
                  & s_axis.tvalid[sel_q] & load_out;
  // Beat limit forces tlast so a runaway frame cannot hold the grant.
  assign cap      = (cnt_q == BW'(MAX_BEATS-1));
  assign last_in  = s_axis.tlast[sel_q] | cap;
  assign fend     = acc & last_in;

  always_comb begin
    s_axis.tready = '0;
    if (state_q == S_PASS && load_out)
      s_axis.tready = {{(NUM_SRC-1){1'b0}}, 1'b1} << sel_q;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == S_ARB): begin
        if (found) begin
          sel_d   = pick;
          state_d = S_PASS;
        end
      end
      (state_q == S_PASS): begin
        if (acc) begin
          if (last_in) begin
            cnt_d   = '0;
            state_d = S_ARB;
            rr_d    = (sel_q == ID_WIDTH'(NUM_SRC-1))
                    ? '0 : sel_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ARB;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q  <= '0;
      vld_q  <= 1'b0;
      lst_q  <= 1'b0;
      tid_q  <= '0;
      fcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (acc) begin
        dat_q <= s_axis.tdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
        vld_q <= 1'b1;
        lst_q <= last_in;
        tid_q <= sel_q;
      end else if (out_hs) begin
        vld_q <= 1'b0;
      end
      if (out_hs && lst_q)
        fcnt_q <= fcnt_q + 16'd1;
      if (fend && !s_axis.tlast[sel_q])
        err_q <= 1'b1;
    end
  end

  assign m_axis.tdata  = dat_q;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tlast  = lst_q;
  assign m_axis.tid    = tid_q;
  assign frame_cnt     = fcnt_q;
  assign oversize_err  = err_q;
  assign busy          = (state_q == S_PASS);

endmodule

// File: tb/tb_axis_frame_arb.sv
// Bench for axis_frame_arb: directed steps then random traffic, checked
// against a queue-based model of grants, truncation and output beats.
module tb_axis_frame_arb;
  localparam int DW   = 32;
  localparam int NS   = 4;
  localparam int IDW  = 2;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic           l;
    logic [IDW-1:0] t;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_frame_arb_if #(.DW(DW), .N(NS), .IDW(IDW)) s_if ();
  axis_frame_arb_if #(.DW(DW), .N(1), .IDW(IDW)) m_if ();
  logic [15:0] frame_cnt;
  logic        oversize_err;
  logic        busy;

  axis_frame_arb #(
    .DATA_WIDTH(DW), .NUM_SRC(NS),
    .ID_WIDTH(IDW), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis(s_if), .m_axis(m_if),
    .frame_cnt(frame_cnt),
    .oversize_err(oversize_err),
    .busy(busy)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  logic [DW:0] srcq[NS][$];
  bit en[NS];
  int acc_cnt[NS];
  beat_t pend[$];
  beat_t log_q[$];
  int log_cyc[$];
  bit mb;
  int mg, mrr, mcnt, cyc, pushed;
  logic [15:0] efc;
  logic eerr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(int rr, logic [NS-1:0] v);
    for (int k = 0; k < NS; k++)
      if (v[(rr+k)%NS]) return (rr+k)%NS;
    return -1;
  endfunction

  function automatic bit drained();
    bit e;
    e = (pend.size() == 0) && !mb;
    for (int i = 0; i < NS; i++)
      if (srcq[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic drive();
    logic [DW:0] h;
    for (int i = 0; i < NS; i++) begin
      h = '0;
      if (srcq[i].size() != 0) h = srcq[i][0];
      s_if.tvalid[i] = (srcq[i].size() != 0) && en[i];
      s_if.tdata[i*DW +: DW] = h[DW-1:0];
      s_if.tlast[i] = h[DW];
    end
  endtask

  task automatic push(int s, logic [DW-1:0] d, logic l);
    logic [DW:0] e;
    e = {l, d};
    srcq[s].push_back(e);
    pushed++;
  endtask

  task automatic step();
    logic [NS-1:0] er;
    beat_t b;
    logic [DW:0] sb;
    int p;
    @(negedge clk);
    er = '0;
    if (mb && (pend.size() == 0 || m_if.tready[0])) er[mg] = 1'b1;
    if (chk_en) begin
      chk("s_tready", s_if.tready, er);
      chk("m_tvalid", m_if.tvalid, pend.size() != 0);
      if (pend.size() != 0) begin
        chk("m_tdata", m_if.tdata, pend[0].d);
        chk("m_tlast", m_if.tlast, pend[0].l);
        chk("m_tid", m_if.tid, pend[0].t);
      end
      chk("busy", busy, mb);
      chk("frame_cnt", frame_cnt, efc);
      chk("oversize", oversize_err, eerr);
    end
    if (rst) begin
      mb = 0; mrr = 0; mcnt = 0;
      pend.delete();
      efc = '0; eerr = 1'b0;
    end else begin
      if (pend.size() != 0 && m_if.tready[0]) begin
        b = pend.pop_front();
        log_q.push_back(b);
        log_cyc.push_back(cyc);
        if (b.l) efc = efc + 16'd1;
      end
      if (!mb) begin
        p = pick(mrr, s_if.tvalid);
        if (p >= 0) begin
          mb = 1; mg = p; mcnt = 0;
        end
      end else if (s_if.tvalid[mg] && er[mg]) begin
        sb = srcq[mg].pop_front();
        b.d = sb[DW-1:0];
        b.t = IDW'(mg);
        b.l = sb[DW] || (mcnt == MAXB-1);
        pend.push_back(b);
        acc_cnt[mg]++;
        mcnt++;
        if (b.l) begin
          if (!sb[DW]) eerr = 1'b1;
          mrr = (mg + 1) % NS;
          mb = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run(int lim);
    int n = 0;
    while (!drained() && n < lim) begin
      step();
      n++;
    end
    chk("drain", drained(), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      acc_cnt[i] = 0;
    end
    drive();
    step();
    rst = 1'b0;
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_tid", m_if.tid, 0);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tready", s_if.tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_err", oversize_err, 0);
    log_q.delete();
    log_cyc.delete();
    pushed = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    s_if.tid = '0;
    m_if.tready = 1'b1;
    for (int i = 0; i < NS; i++) en[i] = 1;
    mb = 0; mrr = 0; mcnt = 0; cyc = 0; pushed = 0;
    efc = '0; eerr = 1'b0;
    drive();
    do_reset();
    chk_en = 1;

    // single source, 3-beat frame
    push(2, 32'hA0, 0); push(2, 32'hA1, 0); push(2, 32'hA2, 1);
    drive();
    run(50);
    chk("t1_len", log_q.size(), 3);
    for (int k = 0; k < 3 && k < log_q.size(); k++) begin
      chk("t1_data", log_q[k].d, 32'hA0 + k);
      chk("t1_tid", log_q[k].t, 2);
      chk("t1_last", log_q[k].l, k == 2);
      chk("t1_cyc", log_cyc[k] - log_cyc[0], k);
    end
    chk("t1_fcnt", frame_cnt, 1);

    // all sources request, 2-beat frames
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < NS; s++)
        for (int b = 0; b < 2; b++)
          push(s, 32'h100*s + 16*f + b, b == 1);
    drive();
    run(200);
    chk("t2_len", log_q.size(), 16);
    for (int j = 0; j < 8 && 2*j+1 < log_q.size(); j++) begin
      chk("t2_tid0", log_q[2*j].t, j % NS);
      chk("t2_tid1", log_q[2*j+1].t, j % NS);
      chk("t2_data", log_q[2*j+1].d,
          32'h100*(j%NS) + 16*(j/NS) + 1);
      if (j > 0)
        chk("t2_gap", log_cyc[2*j] - log_cyc[2*j-1], 2);
    end

    // backpressure 1,0,1,0 on a 4-beat frame
    do_reset();
    for (int b = 0; b < 4; b++) push(1, 32'hB0 + b, b == 3);
    drive();
    n = 0;
    while (!drained() && n < 60) begin
      m_if.tready = (n % 2 == 0);
      step();
      n++;
    end
    chk("t3_drain", drained(), 1);
    m_if.tready = 1'b1;
    chk("t3_len", log_q.size(), 4);
    for (int k = 0; k < 4 && k < log_q.size(); k++)
      chk("t3_data", log_q[k].d, 32'hB0 + k);

    // truncation at MAX_BEATS = 4
    do_reset();
    for (int b = 1; b <= 6; b++) push(0, 32'hC0 + b, b == 6);
    drive();
    run(60);
    chk("t4_len", log_q.size(), 6);
    for (int k = 0; k < 6 && k < log_q.size(); k++) begin
      chk("t4_data", log_q[k].d, 32'hC1 + k);
      chk("t4_last", log_q[k].l, (k == 3) || (k == 5));
    end
    chk("t4_err", oversize_err, 1);
    chk("t4_fcnt", frame_cnt, 2);

    // reset mid-frame
    do_reset();
    for (int b = 0; b < 5; b++) push(3, 32'hD0 + b, b == 4);
    drive();
    n = 0;
    while (acc_cnt[3] < 2 && n < 20) begin
      step();
      n++;
    end
    chk("t5_two", acc_cnt[3], 2);
    do_reset();
    for (int b = 0; b < 3; b++) push(3, 32'hE0 + b, b == 2);
    drive();
    run(50);
    chk("t5_len", log_q.size(), 3);
    for (int k = 0; k < 3 && k < log_q.size(); k++) begin
      chk("t5_data", log_q[k].d, 32'hE0 + k);
      chk("t5_tid", log_q[k].t, 3);
    end
    chk("t5_fcnt", frame_cnt, 1);

    // grant held across a valid gap
    do_reset();
    for (int b = 0; b < 4; b++) push(1, 32'hF0 + b, b == 3);
    drive();
    step();
    push(0, 32'h90, 0); push(0, 32'h91, 1);
    drive();
    n = 0;
    while (acc_cnt[1] < 1 && n < 20) begin
      step();
      n++;
    end
    en[1] = 0;
    drive();
    for (int c = 0; c < 3; c++) step();
    en[1] = 1;
    drive();
    run(60);
    chk("t6_len", log_q.size(), 6);
    for (int k = 0; k < 6 && k < log_q.size(); k++)
      chk("t6_tid", log_q[k].t, k < 4 ? 1 : 0);
    if (log_q.size() == 6) chk("t6_d4", log_q[4].d, 32'h90);

    // random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int s, len;
        s = $urandom_range(0, NS-1);
        len = $urandom_range(1, 7);
        if (srcq[s].size() < 12)
          for (int b = 0; b < len; b++)
            push(s, $urandom, b == len-1);
      end
      for (int i = 0; i < NS; i++) en[i] = ($urandom_range(0, 9) != 0);
      m_if.tready = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end
    for (int i = 0; i < NS; i++) en[i] = 1;
    m_if.tready = 1'b1;
    drive();
    run(2000);
    chk("rnd_beats", log_q.size(), pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
